// File: rtl/rng_read_arbiter_if.sv
// Handshake/data bundle between the RNG word source, the arbiter and its two consumers.
// The master modport is the arbiter side; the slave modport is the RNG/consumer environment.
interface rng_read_arbiter_if;
  logic        STOP;
  logic [1:0]  REQ;
  logic        RNG_VALID;
  logic [15:0] RNG_DATA;
  logic        RNG_RE;
  logic [15:0] DATA_OUT;
  logic [1:0]  ACK;
  logic        BUSY;
  logic        OWNER;

  modport master (
    input  STOP, REQ, RNG_VALID, RNG_DATA,
    output RNG_RE, DATA_OUT, ACK, BUSY, OWNER
  );

  modport slave (
    output STOP, REQ, RNG_VALID, RNG_DATA,
    input  RNG_RE, DATA_OUT, ACK, BUSY, OWNER
  );
endinterface

// File: rtl/rng_read_arbiter.sv
// Shares the 16-bit RNG word stream between a single-word host reader (0) and a burst reader (1).
// Define TRNG_ARB_PRIO0_EN to give requester 0 fixed priority instead of round-robin.
module rng_read_arbiter #(
  parameter int BURST_LEN = 8
) (
  input logic               CLK,
  input logic               RST,
  rng_read_arbiter_if.master bus
);

  localparam int CW = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_XFER,
    ST_ACKS
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     data_q, data_d;
  logic            grant_sel;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // A lone requester always wins; contention is settled by the pointer or fixed priority.
  always_comb begin
    grant_sel = 1'b0;
    if (bus.REQ == 2'b10) begin
      grant_sel = 1'b1;
    end else if (bus.REQ == 2'b11) begin
`ifdef TRNG_ARB_PRIO0_EN
      grant_sel = 1'b0;
`else
      grant_sel = ptr_q;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;

    case (state_q)
      ST_IDLE: begin
        if (!bus.STOP && (bus.REQ != 2'b00)) begin
          owner_d = grant_sel;
          cnt_d   = grant_sel ? CW'(BURST_LEN - 1) : '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (bus.STOP || !bus.REQ[owner_q]) begin
          state_d = ST_IDLE;
        end else if (bus.RNG_VALID) begin
          state_d = ST_XFER;
        end
      end

      ST_XFER: begin
        data_d  = bus.RNG_DATA;
        state_d = ST_ACKS;
      end

      ST_ACKS: begin
        // The pointer only advances when the grant ran to completion.
        if ((cnt_q != '0) && !bus.STOP && bus.REQ[owner_q]) begin
          cnt_d   = cnt_q - CW'(1);
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
          if (cnt_q == '0) begin
            ptr_d = ~owner_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.RNG_RE   = (state_q == ST_XFER);
  assign bus.ACK      = (state_q == ST_ACKS) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.BUSY     = (state_q != ST_IDLE);
  assign bus.OWNER    = owner_q;
  assign bus.DATA_OUT = data_q;

endmodule

// File: tb/tb_rng_read_arbiter.sv
// Self-checking bench for rng_read_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rng_read_arbiter;

  localparam int BURST_LEN = 8;
  localparam logic [1:0] S_WAITV = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  typedef struct packed {
    logic        active;
    logic        owner;
    logic [9:0]  left;
    logic [1:0]  step;
    logic        ptr;
    logic [15:0] data;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  mdl_t m = '0;
  logic inc_mode = 1'b0;
  int   ack0_cnt = 0;
  int   ack1_cnt = 0;
  logic [1:0]  log_who[$];
  logic [15:0] log_data[$];
  int          log_cyc[$];

  rng_read_arbiter_if bus();

  rng_read_arbiter #(.BURST_LEN(BURST_LEN)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Model: a grant is a number of words still owed to one owner, each word passing
  // through wait-for-valid, read, acknowledge.
  function automatic mdl_t modelStep(input mdl_t cur, input logic stop, input logic [1:0] req,
                                     input logic valid, input logic [15:0] data);
    mdl_t nxt = cur;
    if (!cur.active) begin
      if (!stop && (req != 2'b00)) begin
        if (req == 2'b01) nxt.owner = 1'b0;
        else if (req == 2'b10) nxt.owner = 1'b1;
        else begin
`ifdef TRNG_ARB_PRIO0_EN
          nxt.owner = 1'b0;
`else
          nxt.owner = cur.ptr;
`endif
        end
        nxt.left   = nxt.owner ? 10'(BURST_LEN) : 10'd1;
        nxt.active = 1'b1;
        nxt.step   = S_WAITV;
      end
    end else if (cur.step == S_WAITV) begin
      if (stop || !req[cur.owner]) nxt.active = 1'b0;
      else if (valid) nxt.step = S_READ;
    end else if (cur.step == S_READ) begin
      nxt.data = data;
      nxt.step = S_ACK;
    end else begin
      nxt.left = cur.left - 10'd1;
      if ((nxt.left != 10'd0) && !stop && req[cur.owner]) begin
        nxt.step = S_WAITV;
      end else begin
        nxt.active = 1'b0;
        if (nxt.left == 10'd0) nxt.ptr = ~cur.owner;
      end
    end
    return nxt;
  endfunction

  function automatic logic modelRe();
    return m.active && (m.step == S_READ);
  endfunction

  function automatic logic [1:0] modelAck();
    if (m.active && (m.step == S_ACK)) return m.owner ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) m = '0;
    else m = modelStep(m, bus.STOP, bus.REQ, bus.RNG_VALID, bus.RNG_DATA);
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    checkOutput("cyc_rng_re", bus.RNG_RE, modelRe());
    checkOutput("cyc_ack", bus.ACK, modelAck());
    checkOutput("cyc_busy", bus.BUSY, m.active);
    checkOutput("cyc_owner", bus.OWNER, m.owner);
    checkOutput("cyc_data_out", bus.DATA_OUT, m.data);
    if (bus.ACK == 2'b01) ack0_cnt++;
    if (bus.ACK == 2'b10) ack1_cnt++;
    if (bus.ACK != 2'b00) begin
      log_who.push_back(bus.ACK);
      log_data.push_back(bus.DATA_OUT);
      log_cyc.push_back(cyc);
    end
  end

  task automatic applyStimulus(input logic stop, input logic [1:0] req, input logic valid, input logic [15:0] data);
    bus.STOP      = stop;
    bus.REQ       = req;
    bus.RNG_VALID = valid;
    bus.RNG_DATA  = data;
  endtask

  // Inputs change just after the falling edge; in incrementing mode a new word appears after each ACK.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (inc_mode && (modelAck() != 2'b00)) bus.RNG_DATA = bus.RNG_DATA + 16'd1;
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 2'b00, 1'b0, 16'h0000);
    inc_mode = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int base;
    int b0;
    int b1;
    applyStimulus(1'b0, 2'b00, 1'b0, 16'h0000);
    #1 rst = 1'b1;
    tick(2);
    rst = 1'b0;
    checkOutput("rst_rng_re", bus.RNG_RE, 1'b0);
    checkOutput("rst_ack", bus.ACK, 2'b00);
    checkOutput("rst_data_out", bus.DATA_OUT, 16'h0000);
    checkOutput("rst_busy", bus.BUSY, 1'b0);
    checkOutput("rst_owner", bus.OWNER, 1'b0);

    // Single-word grants to requester 0.
    applyStimulus(1'b0, 2'b01, 1'b1, 16'hA5A5);
    tick(1);
    checkOutput("t1_c1_busy", bus.BUSY, 1'b1);
    checkOutput("t1_c1_re", bus.RNG_RE, 1'b0);
    tick(1);
    checkOutput("t1_c2_re", bus.RNG_RE, 1'b1);
    tick(1);
    checkOutput("t1_c3_ack", bus.ACK, 2'b01);
    checkOutput("t1_c3_data", bus.DATA_OUT, 16'hA5A5);
    checkOutput("t1_c3_re", bus.RNG_RE, 1'b0);
    checkOutput("t1_model_ack", modelAck(), 2'b01);
    tick(1);
    checkOutput("t1_c4_busy", bus.BUSY, 1'b0);
    checkOutput("t1_c4_data_hold", bus.DATA_OUT, 16'hA5A5);
    tick(2);
    checkOutput("t1_c6_re", bus.RNG_RE, 1'b1);
    tick(1);
    checkOutput("t1_c7_ack", bus.ACK, 2'b01);
    applyStimulus(1'b0, 2'b00, 1'b1, 16'hA5A5);
    tick(3);

`ifndef TRNG_ARB_PRIO0_EN
    // Round-robin with incrementing data: one word to 0, a burst to 1, one word to 0.
    doReset();
    inc_mode = 1'b1;
    base = log_who.size();
    applyStimulus(1'b0, 2'b11, 1'b1, 16'h0000);
    for (int i = 0; i < 200 && log_who.size() < base + 10; i++) tick(1);
    checkOutput("t2_ack_count", log_who.size() - base, 10);
    for (int k = 0; k < 10 && (base + k) < log_who.size(); k++) begin
      checkOutput("t2_who", log_who[base + k], ((k == 0) || (k == 9)) ? 2'b01 : 2'b10);
      checkOutput("t2_data", log_data[base + k], 16'(k));
      if (k > 0) checkOutput("t2_spacing", log_cyc[base + k] - log_cyc[base + k - 1],
                             ((k == 1) || (k == 9)) ? 4 : 3);
    end
    applyStimulus(1'b0, 2'b00, 1'b1, bus.RNG_DATA);
    inc_mode = 1'b0;
    tick(4);
`endif

    // Unbounded wait for RNG_VALID.
    doReset();
    applyStimulus(1'b0, 2'b10, 1'b0, 16'h3C3C);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkOutput("t3_wait_re", bus.RNG_RE, 1'b0);
      checkOutput("t3_wait_busy", bus.BUSY, 1'b1);
    end
    bus.RNG_VALID = 1'b1;
    tick(1);
    checkOutput("t3_re_after_valid", bus.RNG_RE, 1'b1);
    tick(1);
    checkOutput("t3_ack", bus.ACK, 2'b10);
    checkOutput("t3_data", bus.DATA_OUT, 16'h3C3C);
    bus.REQ = 2'b00;
    tick(2);
    checkOutput("t3_abort_idle", bus.BUSY, 1'b0);

    // STOP in WAIT before word 4 of the burst, then a full re-grant to requester 1.
    doReset();
    inc_mode = 1'b1;
    b0 = ack0_cnt;
    b1 = ack1_cnt;
    applyStimulus(1'b0, 2'b11, 1'b1, 16'h0000);
    for (int i = 0; i < 100 && (ack1_cnt - b1) < 3; i++) tick(1);
    tick(1);
    bus.STOP = 1'b1;
    tick(1);
    checkOutput("t4_stop_re", bus.RNG_RE, 1'b0);
    checkOutput("t4_stop_busy", bus.BUSY, 1'b0);
    tick(2);
    checkOutput("t4_stop_ack1_count", ack1_cnt - b1, 3);
    checkOutput("t4_stop_ack0_count", ack0_cnt - b0, 1);
    b0 = ack0_cnt;
    b1 = ack1_cnt;
    bus.STOP = 1'b0;
    for (int i = 0; i < 100 && (ack0_cnt - b0) < 1; i++) tick(1);
    checkOutput("t4_regrant_ack1_count", ack1_cnt - b1, 8);
    checkOutput("t4_then_ack0", ack0_cnt - b0, 1);
    applyStimulus(1'b0, 2'b00, 1'b1, 16'h0000);
    inc_mode = 1'b0;
    tick(4);

    // Asynchronous reset in XFER, then requester 0 wins the first contention.
    doReset();
    applyStimulus(1'b0, 2'b01, 1'b1, 16'h1234);
    tick(6);
    checkOutput("t5_pre_re", bus.RNG_RE, 1'b1);
    checkOutput("t5_pre_data", bus.DATA_OUT, 16'h1234);
    #1 rst = 1'b1;
    #1;
    checkOutput("t5_async_re", bus.RNG_RE, 1'b0);
    checkOutput("t5_async_ack", bus.ACK, 2'b00);
    checkOutput("t5_async_data", bus.DATA_OUT, 16'h0000);
    checkOutput("t5_async_busy", bus.BUSY, 1'b0);
    tick(1);
    rst = 1'b0;
    base = log_who.size();
    applyStimulus(1'b0, 2'b11, 1'b1, 16'h5555);
    for (int i = 0; i < 20 && log_who.size() <= base; i++) tick(1);
    checkOutput("t5_grant_seen", log_who.size() > base, 1'b1);
    if (log_who.size() > base) begin
      checkOutput("t5_first_owner", log_who[base], 2'b01);
      checkOutput("t5_first_data", log_data[base], 16'h5555);
    end
    applyStimulus(1'b0, 2'b00, 1'b1, 16'h5555);
    tick(4);

`ifdef TRNG_ARB_PRIO0_EN
    // Fixed priority: requester 0 starves 1, but a running burst is not preempted.
    doReset();
    b0 = ack0_cnt;
    b1 = ack1_cnt;
    applyStimulus(1'b0, 2'b11, 1'b1, 16'h7777);
    tick(20);
    checkOutput("t6_ack0_count", ack0_cnt - b0, 5);
    checkOutput("t6_ack1_count", ack1_cnt - b1, 0);
    bus.REQ = 2'b10;
    b0 = ack0_cnt;
    b1 = ack1_cnt;
    for (int i = 0; i < 100 && (ack1_cnt - b1) < 2; i++) tick(1);
    bus.REQ = 2'b11;
    for (int i = 0; i < 100 && (ack0_cnt - b0) < 1; i++) tick(1);
    checkOutput("t6_burst_complete", ack1_cnt - b1, 8);
    checkOutput("t6_ack0_after", ack0_cnt - b0, 1);
    applyStimulus(1'b0, 2'b00, 1'b1, 16'h7777);
    tick(4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rng_read_arbiter.md
Name: rng_read_arbiter

Overview:
- Shares the 16-bit RNG word stream between two consumers.
- Requester 0 is the host register read path and takes one word per grant.
- Requester 1 is the statistics/health path and takes BURST_LEN words per grant.
- Sequences the RNG read-enable pulse, latches each word and routes it to the granted requester. Sits between the RNG unit's data output and its consumers.

Parameters:
BURST_LEN, 8, words delivered per requester-1 grant; legal range 1..256.
CW, $clog2(BURST_LEN)+1, internal width of the burst word counter; derived, never overridden.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST  in  1  asynchronous, active-high reset.
STOP  in  1  suspends arbitration while high.
REQ  in  2  level request; bit i belongs to requester i.
RNG_VALID  in  1  RNG_DATA holds an unread word.
RNG_DATA  in  16  RNG word; sampled only in XFER.
RNG_RE  out  1  one-cycle consume pulse to the RNG unit.
DATA_OUT  out  16  last delivered word, registered.
ACK  out  2  one-hot, one-cycle pulse; DATA_OUT is valid for that requester in this cycle.
BUSY  out  1  high in every state except IDLE.
OWNER  out  1  current or last granted requester.

Behaviour:
- Reset values: RNG_RE=0, ACK=0, DATA_OUT=0, BUSY=0, OWNER=0; round-robin pointer PTR=0; state IDLE; counter=0. Reset takes effect immediately, in any state.
- FSM states: IDLE, WAIT, XFER, ACKS.
- IDLE:
  - If STOP=0 and REQ!=0, select the owner: the single requester if only one is requesting; PTR if both are requesting.
  - Latch OWNER. Load counter = 0 for owner 0, or BURST_LEN-1 for owner 1. Go to WAIT.
- WAIT:
  - If STOP=1 or REQ[OWNER]=0: abort to IDLE. No RNG_RE, no ACK; PTR unchanged.
  - Else if RNG_VALID=1: go to XFER.
  - Else stay in WAIT; waiting has no time limit.
- XFER:
  - RNG_RE=1 for exactly this cycle.
  - DATA_OUT<=RNG_DATA at the closing edge. Go to ACKS unconditionally, ignoring STOP and REQ.
- ACKS:
  - ACK[OWNER]=1 for exactly this cycle, with DATA_OUT stable.
  - If counter>0 and STOP=0 and REQ[OWNER]=1: decrement counter, go to WAIT.
  - Otherwise go to IDLE. PTR<=~OWNER only when counter==0, i.e. the grant completed.
- Latency (REQ asserted in IDLE, RNG_VALID high): RNG_RE at cycle +2, ACK at +3.
  - Single word: 4 cycles per grant.
  - Inside a burst: one word every 3 cycles.
- RNG_RE is never asserted on two consecutive cycles; the ACKS cycle lets RNG_VALID update.
- An early-terminated burst (STOP or REQ drop) leaves PTR unchanged. With REQ=2'b11, the same requester is re-granted a full burst.
- ACK bits are mutually exclusive. RNG_RE and ACK are never high in the same cycle.
- DATA_OUT holds its value outside ACKS.

Optional Feature:
TRNG_ARB_PRIO0_EN
- Defined: in IDLE with REQ=2'b11, requester 0 always wins and PTR is ignored. An active requester-1 burst is never preempted; requester 0 is only served at the next IDLE.
- Undefined: strict round-robin as above.

Test Plan:
1. REQ=2'b01, RNG_VALID=1, RNG_DATA=16'hA5A5 held -> RNG_RE at cycle 2, ACK=2'b01 and DATA_OUT=16'hA5A5 at cycle 3; repeats every 4 cycles.
2. REQ=2'b11 held, RNG_DATA incrementing per RNG_RE from 16'h0000, BURST_LEN=8, macro off -> ACK[0] gets 0000; ACK[1] gets 0001..0008 at 3-cycle spacing; ACK[0] gets 0009; pattern repeats.
3. REQ=2'b10, RNG_VALID low for 10 cycles then high -> stays in WAIT with RNG_RE=0, BUSY=1; RNG_RE on the cycle after RNG_VALID rises.
4. REQ=2'b11, STOP pulsed high in WAIT before word 4 of a requester-1 burst -> exactly 3 ACK[1]; return to IDLE with no RNG_RE. After STOP drops, requester 1 is granted a full 8-word burst.
5. RST pulsed during XFER -> RNG_RE, ACK, DATA_OUT, BUSY go to 0 immediately, before the next edge. After release, with REQ=2'b11, requester 0 is granted first.
6. TRNG_ARB_PRIO0_EN defined, REQ=2'b11 held -> only ACK[0] pulses, every 4 cycles. REQ[0] raised mid requester-1 burst -> the burst completes all 8 words first.
